// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, FSM state type and the single-cycle ALU result
// function shared by alu_seq and its multiplier.
package alu_seq_pkg;

  // Widest datapath supported by the shared result function.
  localparam int unsigned ALU_MAX_W   = 64;
  localparam int unsigned ALU_MAX_SHW = 6;

  localparam logic [3:0] OP_ZERO = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MULU = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [ALU_MAX_W-1:0] y;
    logic                 ovf;
  } alu_res_t;

  // Bit w-1 of v, i.e. the sign bit of a w-wide operand.
  function automatic logic msb_at(input logic [ALU_MAX_W-1:0] v, input int w);
    logic [ALU_MAX_W-1:0] t;
    t = v >> (w - 1);
    return t[0];
  endfunction

  // Single-cycle result for a w-wide datapath. Operands arrive zero-extended
  // to ALU_MAX_W; the result is masked back to w bits. MULU and all unused
  // codes yield zero here.
  function automatic alu_res_t alu_result(
    input logic [3:0]             op,
    input logic [ALU_MAX_W-1:0]   a,
    input logic [ALU_MAX_W-1:0]   b,
    input logic [ALU_MAX_SHW-1:0] sh,
    input int                     w
  );
    logic [ALU_MAX_W-1:0] mask;
    logic [ALU_MAX_W-1:0] bn;
    logic [ALU_MAX_W-1:0] ax;
    logic [ALU_MAX_W-1:0] bx;
    logic [ALU_MAX_W-1:0] sum;
    logic                 lt;
    alu_res_t             r;
    mask = (w >= int'(ALU_MAX_W)) ? '1 : ((ALU_MAX_W'(1) << w) - ALU_MAX_W'(1));
    ax   = msb_at(a, w) ? (a | ~mask) : a;
    bx   = msb_at(b, w) ? (b | ~mask) : b;
    bn   = ~b & mask;
    sum  = '0;
    lt   = 1'b0;
    r    = '0;
    case (op)
      OP_ADD: begin
        sum   = (a + b) & mask;
        r.y   = sum;
        r.ovf = (msb_at(a, w) == msb_at(b, w)) && (msb_at(sum, w) != msb_at(a, w));
      end
      OP_SUB: begin
        sum   = (a + bn + ALU_MAX_W'(1)) & mask;
        r.y   = sum;
        r.ovf = (msb_at(a, w) == msb_at(bn, w)) && (msb_at(sum, w) != msb_at(a, w));
      end
      OP_AND: r.y = a & b;
      OP_OR:  r.y = a | b;
      OP_XOR: r.y = a ^ b;
      OP_SLL: r.y = (a << sh) & mask;
      OP_SRL: r.y = a >> sh;
      OP_SRA: begin
        // Shift kept in its own statement so the signed context is not lost
        // to the unsigned mask.
        sum = $signed(ax) >>> sh;
        r.y = sum & mask;
      end
      OP_SLT: begin
        lt  = $signed(ax) < $signed(bx);
        r.y = {{(ALU_MAX_W-1){1'b0}}, lt};
      end
      OP_SLTU: begin
        lt  = a < b;
        r.y = {{(ALU_MAX_W-1){1'b0}}, lt};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add unsigned multiplier, one bit per cycle.
// The product of a*b appears on {hi, lo} after WIDTH steps.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // One shift-add step: conditional add into the high half, carry kept,
  // then the whole accumulator shifts right by one.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], acc_lo[WIDTH-1:1]};
  end

  // busy drops during the final step and lo/hi already show that step's
  // outcome, so the caller captures the product on the edge the last step
  // retires instead of one cycle later.
  assign busy = (count > CW'(1));
  assign lo   = (count != '0) ? lo_next : acc_lo;
  assign hi   = (count != '0) ? hi_next : acc_hi;

  // Operand capture on load, then one step per cycle until the counter empties.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= a;
      acc_hi <= '0;
      acc_lo <= b;
      count  <= CW'(WIDTH);
    end else if (count != '0) begin
      acc_hi <= hi_next;
      acc_lo <= lo_next;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with registered result, zero/overflow flags and a
// start/busy/done handshake. Define ALU_SEQ_MUL_EN to build the iterative
// MULU multiplier; without it MULU decodes as ZERO and busy is tied low.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             zero,
  output logic             overflow
);

  state_t                 state;
  alu_res_t               res;
  logic [ALU_MAX_SHW-1:0] shamt;
  logic [WIDTH-1:0]       y_next;
  logic                   ovf_next;

  assign shamt = ALU_MAX_SHW'(data_b[SHW-1:0]);

  // Single-cycle datapath evaluated on the live inputs; its result is
  // registered on the accepting start edge, which latches the operands.
  always_comb begin
    res      = alu_result(select, ALU_MAX_W'(data_a), ALU_MAX_W'(data_b), shamt, WIDTH);
    y_next   = WIDTH'(res.y);
    ovf_next = res.ovf;
  end

`ifdef ALU_SEQ_MUL_EN
  logic             mul_load;
  logic             mul_busy;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH-1:0] mul_hi;

  assign mul_load = (state == ST_IDLE) && start && (select == OP_MULU);

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk  (clk),
    .reset(reset),
    .load (mul_load),
    .a    (data_a),
    .b    (data_b),
    .busy (mul_busy),
    .lo   (mul_lo),
    .hi   (mul_hi)
  );
`else
  assign busy = 1'b0;
`endif

  // Control FSM and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      y        <= '0;
      y_hi     <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      done     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      busy     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
`ifdef ALU_SEQ_MUL_EN
            if (select == OP_MULU) begin
              busy  <= 1'b1;
              state <= ST_MUL;
            end else
`endif
            begin
              y        <= y_next;
              y_hi     <= '0;
              zero     <= (y_next == '0);
              overflow <= ovf_next;
              done     <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
`ifdef ALU_SEQ_MUL_EN
          if (!mul_busy) begin
            y        <= mul_lo;
            y_hi     <= mul_hi;
            zero     <= (mul_lo == '0);
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
`else
          state <= ST_IDLE;
`endif
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=32).
module tb_alu_seq;

  localparam logic [3:0] C_ZERO = 4'b0000;
  localparam logic [3:0] C_ADD  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SLL  = 4'b0101;
  localparam logic [3:0] C_SRL  = 4'b0110;
  localparam logic [3:0] C_Z7   = 4'b0111;
  localparam logic [3:0] C_SUB  = 4'b1000;
  localparam logic [3:0] C_SLT  = 4'b1001;
  localparam logic [3:0] C_SLTU = 4'b1010;
  localparam logic [3:0] C_SRA  = 4'b1011;
  localparam logic [3:0] C_MULU = 4'b1100;
  localparam logic [3:0] C_Z15  = 4'b1111;

`ifdef ALU_SEQ_MUL_EN
  localparam int          EXP_MUL_CYC  = 33;
  localparam int          EXP_MUL_BUSY = 32;
  localparam logic [31:0] EXP_MUL_Y    = 32'hFFFF_FFFE;
  localparam logic [31:0] EXP_MUL_YHI  = 32'h1;
  localparam logic        EXP_BUSY_MID = 1'b1;
`else
  localparam int          EXP_MUL_CYC  = 1;
  localparam int          EXP_MUL_BUSY = 0;
  localparam logic [31:0] EXP_MUL_Y    = 32'h0;
  localparam logic [31:0] EXP_MUL_YHI  = 32'h0;
  localparam logic        EXP_BUSY_MID = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic        ov;
  } vec_t;

  localparam int NV = 19;
  localparam vec_t VECS [NV] = '{
    '{C_ADD,  32'h0000_0007, 32'h0000_0005, 32'h0000_000C, 1'b0},
    '{C_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1},
    '{C_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0},
    '{C_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0},
    '{C_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0},
    '{C_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0},
    '{C_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
    '{C_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
    '{C_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
    '{C_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1},
    '{C_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
    '{C_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0},
    '{C_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0},
    '{C_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0},
    '{C_SLL,  32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0},
    '{C_SUB,  32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1},
    '{C_Z7,   32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b0},
    '{C_SRA,  32'h4000_0000, 32'h0000_001F, 32'h0000_0000, 1'b0},
    '{C_Z15,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0}
  };

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  select;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        busy;
  logic        done;
  logic [31:0] y;
  logic [31:0] y_hi;
  logic        zero;
  logic        overflow;

  int tests_run;
  int tests_failed;

  alu_seq #(
    .WIDTH(32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .select  (select),
    .data_a  (data_a),
    .data_b  (data_b),
    .busy    (busy),
    .done    (done),
    .y       (y),
    .y_hi    (y_hi),
    .zero    (zero),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One single-cycle op: done and results one cycle after start, then IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    start  = 1'b1;
    select = v.op;
    data_a = v.a;
    data_b = v.b;
    @(posedge clk); #1;
    start  = 1'b0;
    data_a = ~v.a;
    data_b = ~v.b;
    check($sformatf("v%0d_done", idx), done, 1);
    check($sformatf("v%0d_y", idx), y, v.y);
    check($sformatf("v%0d_zero", idx), zero, (v.y == 32'h0));
    check($sformatf("v%0d_ovf", idx), overflow, v.ov);
    check($sformatf("v%0d_yhi", idx), y_hi, 0);
    @(posedge clk); #1;
    check($sformatf("v%0d_done_low", idx), done, 0);
    check($sformatf("v%0d_y_hold", idx), y, v.y);
  endtask

  initial begin
    int donecyc;
    int nb;
    int extra;
    tests_run    = 0;
    tests_failed = 0;
    reset  = 1'b0;
    start  = 1'b0;
    select = 4'h0;
    data_a = '0;
    data_b = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_y", y, 0);
    check("rst_yhi", y_hi, 0);
    check("rst_zero", zero, 1);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, VECS[i]);

    // start held during DONE is dropped
    @(negedge clk);
    start  = 1'b1;
    select = C_ADD;
    data_a = 32'd7;
    data_b = 32'd5;
    @(posedge clk); #1;
    check("drop_done", done, 1);
    select = C_OR;
    data_a = 32'd1;
    data_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("drop_no_done", done, 0);
    check("drop_y", y, 32'd12);
    @(posedge clk); #1;
    check("drop_no_done2", done, 0);
    check("drop_y2", y, 32'd12);

    // MULU with an ignored ADD request and operand changes in flight
    @(negedge clk);
    start  = 1'b1;
    select = C_MULU;
    data_a = 32'hFFFF_FFFF;
    data_b = 32'd2;
    @(posedge clk); #1;
    start  = 1'b0;
    data_a = '0;
    data_b = '0;
    donecyc = 0;
    nb      = 0;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        donecyc = k;
        break;
      end
      if (busy) nb++;
      if (k == 5) begin
        start  = 1'b1;
        select = C_ADD;
        data_a = 32'd1;
        data_b = 32'd1;
      end
      if (k == 6) start = 1'b0;
      @(posedge clk); #1;
    end
    check("mul_done_cycle", donecyc, EXP_MUL_CYC);
    check("mul_busy_cycles", nb, EXP_MUL_BUSY);
    check("mul_busy_at_done", busy, 0);
    check("mul_y", y, EXP_MUL_Y);
    check("mul_yhi", y_hi, EXP_MUL_YHI);
    check("mul_zero", zero, (EXP_MUL_Y == 32'h0));
    check("mul_ovf", overflow, 0);
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("mul_extra_done", extra, 0);
    check("mul_y_hold", y, EXP_MUL_Y);

    // reset in the middle of a MULU
    run_vec(100, VECS[0]);
    @(negedge clk);
    start  = 1'b1;
    select = C_MULU;
    data_a = 32'd3;
    data_b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      @(posedge clk); #1;
    end
    check("mid_busy", busy, EXP_BUSY_MID);
    reset = 1'b0;
    #1;
    check("arst_y", y, 0);
    check("arst_yhi", y_hi, 0);
    check("arst_zero", zero, 1);
    check("arst_ovf", overflow, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    extra = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("arst_no_done", extra, 0);
    check("arst_y_hold", y, 0);
    check("arst_busy_hold", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the multicycle MIPS datapath. Successor to the 3-bit-select combinational ALU. Adds:
- a 4-bit operation field with SUB, SLT, SLTU and SRA, and shifts by a variable amount;
- registered results with zero and overflow flags;
- an optional iterative unsigned multiplier behind a start/busy/done handshake.

The control FSM drives `start` and waits for `done` before it writes the result register.

## Interface
- `WIDTH`, default 32: operand and result width. Must be ≥ 4 and a power of two.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived, never overridden.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: operation request. Sampled only in IDLE.
- `select` in 4: operation code.
- `data_a` in WIDTH: operand A.
- `data_b` in WIDTH: operand B. `data_b[SHW-1:0]` is the shift amount for shift operations.
- `busy` out 1: high while a multicycle operation is in progress.
- `done` out 1: one-cycle pulse when `y`, `y_hi` and the flags are valid.
- `y` out WIDTH: result, low word.
- `y_hi` out WIDTH: high word of MULU. Zero for every other operation.
- `zero` out 1: `y == 0`.
- `overflow` out 1: signed overflow of ADD or SUB. 0 for all other operations.

## Operation
- Op codes:
  - 0000 ZERO
  - 0001 ADD
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL
  - 0110 SRL
  - 0111 ZERO
  - 1000 SUB
  - 1001 SLT (signed)
  - 1010 SLTU
  - 1011 SRA
  - 1100 MULU
  - 1101–1111 ZERO
- Codes 0001–0111 keep their legacy meanings. Shifts now use `data_b[SHW-1:0]` instead of a constant 1.
- Operands and `select` are latched on the accepted `start` edge. Later input changes have no effect on the operation in flight.
- FSM states: IDLE, MUL, DONE.
  - IDLE with `start`=1 and a single-cycle op: compute combinationally and register the result → DONE.
  - IDLE with `start`=1 and MULU: clear the accumulator, set the counter to WIDTH → MUL.
  - MUL: each cycle, if multiplier LSB=1, add the multiplicand to the accumulator high half, then shift right by one (WIDTH+1-bit add, carry kept). Decrement the counter. At counter==1 → DONE.
  - DONE: `done`=1 for exactly one cycle → IDLE.
- `start` is ignored in MUL and DONE. No queueing.
- ADD and SUB wrap modulo 2^WIDTH.
- `overflow` = operand signs equal (after B inversion for SUB) and result sign differs.
- SLT/SLTU: `y` = {WIDTH-1 zeros, lt}.
- SRA replicates `data_a[WIDTH-1]`.
- Shift amount 0 returns `data_a` unchanged.
- `y`, `y_hi`, `zero` and `overflow` hold their last values until the next DONE.

## Timing
- Reset values:
  - FSM: IDLE.
  - `y`=0, `y_hi`=0, `zero`=1, `overflow`=0, `busy`=0, `done`=0.
  - Multiplier counter and accumulator: 0.
- Single-cycle op: `start` at edge N → `done`=1 and outputs valid in cycle N+1.
- Back-to-back single-cycle ops:
  - A new op can start in the cycle after `done`, which gives 2 cycles per op.
  - A `start` asserted during DONE is dropped.
- MULU: `start` at edge N → `busy`=1 during cycles N+1..N+WIDTH, `done`=1 in cycle N+WIDTH+1 with `busy`=0.
- Reset asserted mid-operation: all state and outputs return to reset values immediately (asynchronous). No `done` is issued for the aborted op.

## Configuration
- `ALU_SEQ_MUL_EN` defined:
  - The multiplier sub-module and the MUL state are built.
  - MULU behaves as described above.
- `ALU_SEQ_MUL_EN` undefined:
  - MULU decodes as ZERO: single-cycle, `y`=0, `y_hi`=0.
  - `busy` is tied to 0.
  - No multiplier logic is synthesised.

## Structure
- `alu_seq_pkg`:
  - 4-bit op-code localparams (OP_ZERO … OP_MULU);
  - FSM state enum (ST_IDLE, ST_MUL, ST_DONE);
  - the single-cycle result function.
- Sub-module `alu_seq_mul`:
  - iterative shift-add unsigned multiplier, WIDTH-parametrised;
  - ports: `clk`, `reset`, `load`, `a`, `b`, `busy`, `lo`, `hi`;
  - built only under `ALU_SEQ_MUL_EN`.
- Top level holds the FSM, operand latches, the combinational single-cycle datapath and the output registers.

## Test plan
- ADD, A=7, B=5 → `y`=12, `zero`=0, `overflow`=0, `done` one cycle after `start`.
- SUB, A=0x8000_0000, B=1 → `y`=0x7FFF_FFFF, `overflow`=1. Then SUB 5−5 → `y`=0, `zero`=1.
- Shifts:
  - SLL, A=1, B=31 → 0x8000_0000.
  - SRA, A=0x8000_0000, B=4 → 0xF800_0000.
  - SRL same operands → 0x0800_0000.
  - SLT, A=−1, B=1 → 1; SLTU with the same operands → 0.
- MULU, A=0xFFFF_FFFF, B=2 → `busy` high for 32 cycles, `done` at cycle 33, `y`=0xFFFF_FFFE, `y_hi`=1.
  - Without `ALU_SEQ_MUL_EN`: `done` at cycle 1, `y`=0.
- During MULU:
  - pulse `start` with ADD 1+1 → ignored; MULU result unchanged and no extra `done`.
  - assert `reset` at cycle 10 → all outputs return to reset values and no `done` follows.
